ft_cmd_bridge: RTL

Byte-stream command bridge that sits directly downstream of the FT245 protocol master's RX FIFO and upstream of its TX FIFO, in the same clock domain as both FIFO user ports. It pulls host command packets byte by byte from the RX FIFO and executes them as single register-bus reads and writes. It then pushes response bytes into the TX FIFO, giving the host memory-mapped access to FPGA registers over the FTDI link.

---
 rtl/ft_cmd_bridge.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ft_cmd_bridge.sv
// Byte-stream command bridge: decodes host read/write packets from the RX FIFO into register-bus
// cycles and returns responses through the TX FIFO. Define FT_CMD_BRIDGE_TIMEOUT_EN for the bus ack timeout.
module ft_cmd_bridge #(
  parameter int ADDR_BYTES    = 2,
  parameter int DATA_BYTES    = 4,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      rxfifo_rd,
  input  logic [7:0]                rxfifo_data,
  input  logic                      rxfifo_valid,
  input  logic                      rxfifo_empty,
  output logic [7:0]                txfifo_data,
  output logic                      txfifo_wr,
  input  logic                      txfifo_full,
  output logic [8*ADDR_BYTES-1:0]   bus_addr,
  output logic [8*DATA_BYTES-1:0]   bus_wdata,
  output logic                      bus_wen,
  output logic                      bus_ren,
  input  logic [8*DATA_BYTES-1:0]   bus_rdata,
  input  logic                      bus_ack,
  output logic                      busy,
  output logic [7:0]                err_cnt
);

  localparam int AW   = 8 * ADDR_BYTES;
  localparam int DW   = 8 * DATA_BYTES;
  localparam int RW   = DW + 8;
  localparam int CMAX = (ADDR_BYTES > DATA_BYTES + 1) ? ADDR_BYTES : DATA_BYTES + 1;
  localparam int CW   = $clog2(CMAX);

  localparam logic [2:0] CMD_S  = 3'd0;
  localparam logic [2:0] ADDR_S = 3'd1;
  localparam logic [2:0] DATA_S = 3'd2;
  localparam logic [2:0] BUS_S  = 3'd3;
  localparam logic [2:0] RESP_S = 3'd4;

  localparam logic [7:0] OP_WR  = 8'h57;
  localparam logic [7:0] OP_RD  = 8'h52;
  localparam logic [7:0] OP_TMO = 8'h54;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_wr_q, is_wr_d;
  logic          rd_q, rd_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [RW-1:0] resp_q, resp_d;
  logic          single_q, single_d;
  logic [7:0]    err_q, err_d;
  logic          cap;
  logic          err_inc;
  logic          tmo_hit;

`ifdef FT_CMD_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS);
  logic [TW-1:0] tmo_q, tmo_d;

  // Counts request cycles; the last allowed cycle is TIMEOUT_TICKS-1 after BUS_S entry.
  always_comb begin
    tmo_d = (state_q == BUS_S) ? tmo_q + TW'(1) : '0;
  end

  assign tmo_hit = (state_q == BUS_S) && (tmo_q == TW'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  logic unused_timeout_ticks;
  assign unused_timeout_ticks = ^TIMEOUT_TICKS;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    resp_d   = resp_q;
    single_d = single_q;
    err_d    = err_q;
    err_inc  = 1'b0;
    // Valid is only honoured for a read we issued, so a byte in flight across reset is dropped.
    cap      = pend_q && rxfifo_valid;
    pend_d   = (pend_q && !rxfifo_valid) || rd_q;

    case (state_q)
      CMD_S: begin
        if (cap) begin
          if (rxfifo_data == OP_WR || rxfifo_data == OP_RD) begin
            is_wr_d = (rxfifo_data == OP_WR);
            cnt_d   = '0;
            state_d = ADDR_S;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      ADDR_S: begin
        if (cap) begin
          addr_d = (addr_q << 8) | AW'(rxfifo_data);
          if (cnt_q == CW'(ADDR_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = is_wr_q ? DATA_S : BUS_S;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DATA_S: begin
        if (cap) begin
          wdata_d = (wdata_q << 8) | DW'(rxfifo_data);
          if (cnt_q == CW'(DATA_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = BUS_S;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      BUS_S: begin
        if (bus_ack) begin
          cnt_d   = '0;
          state_d = RESP_S;
          if (is_wr_q) begin
            resp_d   = {OP_WR, {DW{1'b0}}};
            single_d = 1'b1;
          end else begin
            resp_d   = {OP_RD, bus_rdata};
            single_d = 1'b0;
          end
        end else if (tmo_hit) begin
          cnt_d    = '0;
          state_d  = RESP_S;
          resp_d   = {OP_TMO, {DW{1'b0}}};
          single_d = 1'b1;
          err_inc  = 1'b1;
        end
      end
      RESP_S: begin
        // The head byte of resp_q stays on txfifo_data until the FIFO accepts it.
        if (!txfifo_full) begin
          if (single_q || cnt_q == CW'(DATA_BYTES)) begin
            state_d = CMD_S;
          end else begin
            resp_d = resp_q << 8;
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = CMD_S;
    endcase

    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;

    rd_d = (state_d == CMD_S || state_d == ADDR_S || state_d == DATA_S) &&
           !rxfifo_empty && !pend_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CMD_S;
      cnt_q    <= '0;
      is_wr_q  <= 1'b0;
      rd_q     <= 1'b0;
      pend_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      single_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      rd_q     <= rd_d;
      pend_q   <= pend_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      resp_q   <= resp_d;
      single_q <= single_d;
      err_q    <= err_d;
    end
  end

  assign rxfifo_rd   = rd_q;
  assign txfifo_wr   = (state_q == RESP_S) && !txfifo_full;
  assign txfifo_data = resp_q[RW-1 -: 8];
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_wen     = (state_q == BUS_S) && is_wr_q;
  assign bus_ren     = (state_q == BUS_S) && !is_wr_q;
  assign busy        = (state_q != CMD_S);
  assign err_cnt     = err_q;

endmodule
